// File: rtl/vn_update_serial.sv
// Purpose : serial variable-node update of the min-sum decoder; sums channel LLR + DEGREE check messages, emits DEGREE saturated extrinsics.
// Latency : first extrinsic is valid 1 cycle after the last input beat is accepted; one output beat per cycle thereafter.
// Backpr. : in_ready low for the whole EMIT phase (no frame overlap); outputs are held while out_ready is low.
//
// Ports   : clk/rst (sync, active-high); in_valid/in_ready/in_data (beat 0 = LLR, 1..DEGREE = check msgs);
//           out_valid/out_ready/out_data/out_idx/out_last (extrinsic for edge out_idx, last on idx DEGREE-1).
// Option  : define VN_DECISION_EN to add dec_valid/dec_bit/posterior (hard decision + saturated posterior).
module vn_update_serial #(
    parameter int WIDTH         = 8,
    parameter int EXTENDED_BITS = 4,
    parameter int DEGREE        = 3,
    localparam int IDX_W        = (DEGREE > 1) ? $clog2(DEGREE) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_idx,
`ifdef VN_DECISION_EN
    output logic             dec_valid,
    output logic             dec_bit,
    output logic [WIDTH-1:0] posterior,
`endif
    output logic             out_last
);

    localparam int XW    = WIDTH + EXTENDED_BITS;
    localparam int CNT_W = $clog2(DEGREE + 1);

    typedef enum logic {LOAD, EMIT} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [XW-1:0]           total_q, total_d;
    logic [WIDTH-1:0]        msg_q [DEGREE];
    logic [WIDTH-1:0]        msg_d [DEGREE];
    logic [WIDTH-1:0]        out_data_q, out_data_d;
    logic                    out_last_q, out_last_d;
    logic [WIDTH-1:0]        msg_sel;
    logic                    in_fire;

    function automatic logic [XW-1:0] sext(input logic [WIDTH-1:0] v);
        return {{EXTENDED_BITS{v[WIDTH-1]}}, v};
    endfunction

    // Clamp to WIDTH when the bits above the target sign bit are not a pure sign extension.
    function automatic logic [WIDTH-1:0] sat(input logic [XW-1:0] x);
        logic [XW-WIDTH:0] top;
        top = x[XW-1:WIDTH-1];
        if ((&top) || !(|top))
            return x[WIDTH-1:0];
        else if (!x[XW-1])
            return {1'b0, {(WIDTH-1){1'b1}}};
        else
            return {1'b1, {(WIDTH-1){1'b0}}};
    endfunction

    assign in_ready  = (state_q == LOAD) && !rst;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = (state_q == EMIT);
    assign out_data  = out_data_q;
    assign out_idx   = idx_q;
    assign out_last  = out_last_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        total_d = total_q;
        msg_d   = msg_q;
        case (state_q)
            LOAD: begin
                if (in_fire) begin
                    if (cnt_q == '0) begin
                        total_d = sext(in_data);
                    end else begin
                        total_d = total_q + sext(in_data);
                        for (int k = 0; k < DEGREE; k++) begin
                            if (cnt_q == CNT_W'(k + 1)) msg_d[k] = in_data;
                        end
                    end
                    if (cnt_q == CNT_W'(DEGREE)) begin
                        state_d = EMIT;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (idx_q == IDX_W'(DEGREE - 1)) begin
                        state_d = LOAD;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Outputs are precomputed from next-state values so out_data/out_last come straight from flops.
    always_comb begin
        msg_sel = '0;
        for (int k = 0; k < DEGREE; k++) begin
            if (idx_d == IDX_W'(k)) msg_sel = msg_d[k];
        end
        out_data_d = out_data_q;
        out_last_d = 1'b0;
        if (state_d == EMIT) begin
            out_data_d = sat(total_d - sext(msg_sel));
            out_last_d = (idx_d == IDX_W'(DEGREE - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOAD;
            cnt_q      <= '0;
            idx_q      <= '0;
            total_q    <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            for (int k = 0; k < DEGREE; k++) msg_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            total_q    <= total_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            msg_q      <= msg_d;
        end
    end

`ifdef VN_DECISION_EN
    logic             dec_valid_q, dec_valid_d;
    logic             dec_bit_q, dec_bit_d;
    logic [WIDTH-1:0] posterior_q, posterior_d;
    logic             frame_done;

    // The decision is captured on the LOAD->EMIT step and held until the next frame completes.
    assign frame_done = (state_q == LOAD) && (state_d == EMIT);

    always_comb begin
        dec_valid_d = frame_done;
        dec_bit_d   = dec_bit_q;
        posterior_d = posterior_q;
        if (frame_done) begin
            dec_bit_d   = total_d[XW-1];
            posterior_d = sat(total_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_valid_q <= 1'b0;
            dec_bit_q   <= 1'b0;
            posterior_q <= '0;
        end else begin
            dec_valid_q <= dec_valid_d;
            dec_bit_q   <= dec_bit_d;
            posterior_q <= posterior_d;
        end
    end

    assign dec_valid = dec_valid_q;
    assign dec_bit   = dec_bit_q;
    assign posterior = posterior_q;
`endif

endmodule
